// File: rtl/decode_stage.sv
// decode_stage
//   Instruction decode stage of the 16-bit pipelined CPU. Decodes one
//   instruction per cycle, reads two operands from the architectural
//   register file (with same-cycle writeback bypass) and presents a
//   registered ID/EX bundle behind a valid/ready handshake.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   in_instr/in_valid/in_ready   fetch-side instruction handshake
//   flush             drop held bundle and incoming instruction
//   wb_en/wb_rd/wb_data          register file writeback port
//   out_valid/out_ready          execute-side bundle handshake
//   alu_a, alu_b, alu_control, rd, reg_write, illegal   ID/EX bundle
//   illegal_seen      sticky flag, any accepted undefined opcode
module decode_stage #(
    parameter int NUM_REGS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_instr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [2:0]  wb_rd,
    input  logic [15:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_control,
    output logic [2:0]  rd,
    output logic        reg_write,
    output logic        illegal,
    output logic        illegal_seen
);

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [3:0]  f_op;
    logic [2:0]  f_rd;
    logic [2:0]  f_rs1;
    logic [2:0]  f_rs2;
    logic [15:0] imm6_sext;
    logic [15:0] imm9_zext;

    assign f_op      = in_instr[15:12];
    assign f_rd      = in_instr[11:9];
    assign f_rs1     = in_instr[8:6];
    assign f_rs2     = in_instr[5:3];
    assign imm6_sext = {{10{in_instr[5]}}, in_instr[5:0]};
    assign imm9_zext = {7'd0, in_instr[8:0]};

    // ------------------------------------------------------------------
    // Register file. Entry 0 exists but is never written; reads of
    // index 0 are forced to zero independently.
    // ------------------------------------------------------------------
    logic [15:0] regs_q [NUM_REGS];
    logic [15:0] rs1_val;
    logic [15:0] rs2_val;

    // Writeback data is forwarded so an instruction decoded in the same
    // cycle as the write sees the new value.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (f_rs1 != 3'd0) begin
            if (wb_en && (wb_rd == f_rs1)) rs1_val = wb_data;
            else                           rs1_val = regs_q[f_rs1];
        end
        if (f_rs2 != 3'd0) begin
            if (wb_en && (wb_rd == f_rs2)) rs2_val = wb_data;
            else                           rs2_val = regs_q[f_rs2];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en && (wb_rd != 3'd0)) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Opcode decode
    // ------------------------------------------------------------------
    logic [15:0] dec_a;
    logic [15:0] dec_b;
    logic [3:0]  dec_ctrl;
    logic        dec_rw;
    logic        dec_illegal;

    always_comb begin
        dec_a       = '0;
        dec_b       = '0;
        dec_ctrl    = 4'b0000;
        dec_rw      = 1'b0;
        dec_illegal = 1'b0;
        case (f_op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100: begin
                dec_ctrl = f_op;
                dec_a    = rs1_val;
                dec_b    = rs2_val;
                dec_rw   = 1'b1;
            end
            // NOT, SHL, SHR are single-operand: B is forced to zero.
            4'b0101, 4'b0110, 4'b0111: begin
                dec_ctrl = f_op;
                dec_a    = rs1_val;
                dec_rw   = 1'b1;
            end
            4'b1000: begin
                dec_a  = rs1_val;
                dec_b  = imm6_sext;
                dec_rw = 1'b1;
            end
            4'b1001: begin
                dec_b  = imm9_zext;
                dec_rw = 1'b1;
            end
            4'b1111: begin
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
        if (f_rd == 3'd0) dec_rw = 1'b0;
    end

    // ------------------------------------------------------------------
    // Output register stage and handshake
    // ------------------------------------------------------------------
    logic        valid_q,   valid_d;
    logic [15:0] a_q,       a_d;
    logic [15:0] b_q,       b_d;
    logic [3:0]  ctrl_q,    ctrl_d;
    logic [2:0]  rd_q,      rd_d;
    logic        rw_q,      rw_d;
    logic        ill_q,     ill_d;
    logic        seen_q,    seen_d;
    logic        accept;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        rd_d    = rd_q;
        rw_d    = rw_q;
        ill_d   = ill_q;
        seen_d  = seen_q || (accept && dec_illegal);
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            a_d     = dec_a;
            b_d     = dec_b;
            ctrl_d  = dec_ctrl;
            rd_d    = f_rd;
            rw_d    = dec_rw;
            ill_d   = dec_illegal;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            ill_q   <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            ill_q   <= ill_d;
            seen_q  <= seen_d;
        end
    end

    assign out_valid    = valid_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_control  = ctrl_q;
    assign rd           = rd_q;
    assign reg_write    = rw_q;
    assign illegal      = ill_q;
    assign illegal_seen = seen_q;

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage for the 16-bit pipelined CPU. It accepts one 16-bit instruction per cycle from the fetch side and reads two operands from an internal 8×16 register file. It then presents a registered ID/EX bundle to the execute stage: operand A, operand B, the 4-bit ALU control code and the destination register. It is the producer of the ALU's operation encoding and operands. It also owns the architectural register file and its writeback port.

## Interface
- `NUM_REGS`, default 8: number of registers; register index width is 3 bits, fixed.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_instr` input 16: instruction word.
- `in_valid` input 1: `in_instr` is valid.
- `in_ready` output 1: the stage accepts `in_instr` this cycle.
- `flush` input 1: discard held and incoming instructions.
- `wb_en` input 1: register file write enable.
- `wb_rd` input 3: writeback register index.
- `wb_data` input 16: writeback data.
- `out_valid` output 1: the ID/EX bundle is valid.
- `out_ready` input 1: the execute stage accepts the bundle.
- `alu_a` output 16: operand A.
- `alu_b` output 16: operand B.
- `alu_control` output 4: ALU operation code.
- `rd` output 3: destination register.
- `reg_write` output 1: the result must be written back.
- `illegal` output 1: the bundle carries an undefined opcode.
- `illegal_seen` output 1: sticky flag set by any accepted illegal opcode.

## Operation

**Instruction fields**
- `op` = `[15:12]`, `rd` = `[11:9]`, `rs1` = `[8:6]`, `rs2` = `[5:3]`.
- `imm6` = `[5:0]`, sign-extended to 16 bits.
- `imm9` = `[8:0]`, zero-extended to 16 bits.

**Opcode decode**
- `0000`–`0111` (ADD, SUB, AND, OR, XOR, NOT, SHL, SHR):
  - `alu_control` = `op`.
  - `alu_a` = R[rs1].
  - `alu_b` = R[rs2], except for NOT/SHL/SHR, where `alu_b` = 0.
  - `reg_write` = 1.
- `1000` ADDI: `alu_control` = `0000`, `alu_a` = R[rs1], `alu_b` = sext(imm6), `reg_write` = 1.
- `1001` LI: `alu_control` = `0000`, `alu_a` = 0, `alu_b` = zext(imm9), `reg_write` = 1.
- `1111` NOP: `alu_control` = `0000`, both operands 0, `reg_write` = 0, `illegal` = 0.
- `1010`–`1110`: same outputs as NOP, but `illegal` = 1; `illegal_seen` is set when the instruction is accepted.
- `rd` = 0 forces `reg_write` = 0.

**Register file**
- R0 always reads 0; writes to R0 are ignored.
- Writeback: on a rising edge with `wb_en` = 1, R[`wb_rd`] <= `wb_data`.
- Writeback is independent of stall and flush.
- Bypass: if `wb_en` = 1, `wb_rd` equals the source index, and that index is not 0, the operand read in the same cycle uses `wb_data`, not the stored value.

**Handshake (one output register stage)**
- `in_ready` = !`out_valid` || `out_ready`. The combinational `in_ready` depends only on `out_valid` and `out_ready`, never on `in_valid`.
- Accept = `in_valid` && `in_ready` && !`flush`. On accept, the bundle register loads the decoded instruction and `out_valid` <= 1.
- `out_valid` && `out_ready` with no accept: `out_valid` <= 0.
- `out_valid` && !`out_ready`: the bundle is held, bit-stable.
- `flush` = 1: `out_valid` <= 0 and the incoming instruction is dropped.
  - `flush` has priority over accept and over hold.
  - `illegal_seen` is not set by a dropped instruction.
- Bundle fields other than `out_valid` keep their last value when not loaded; they are don't-care while `out_valid` = 0.

## Timing
- Latency: 1 cycle from accept to `out_valid`. Throughput is 1 instruction per cycle when `out_ready` = 1.
- Reset (`rst_n` = 0 at a rising edge):
  - `out_valid`, `alu_a`, `alu_b`, `alu_control`, `rd`, `reg_write`, `illegal` and `illegal_seen` all go to 0.
  - R1–R7 are cleared to 0.
  - Reset overrides `wb_en`, `flush` and accept in the same cycle.
- Reset while stalled: the held bundle is lost. After release, `in_ready` = 1 in the first cycle.
- `illegal_seen` is cleared only by reset.

## Test plan
1. **Reset and LI:** reset, then LI R1, 0x1FF -> next cycle `out_valid` = 1, `alu_a` = 0, `alu_b` = 0x01FF, `alu_control` = 0, `rd` = 1, `reg_write` = 1.
2. **Writeback bypass:** write R2 = 0x1234 via writeback in the same cycle that ADD R3, R2, R2 is accepted -> `alu_a` = `alu_b` = 0x1234. A write of 0xFFFF to R0, followed by reading R0, returns 0.
3. **ADDI sign extension and shift operands:** ADDI R4, R1, imm6 = 0x3F -> `alu_b` = 0xFFFF, `alu_control` = 0. SHL R5, R1 -> `alu_b` = 0, `alu_control` = 0110.
4. **Backpressure:**
   - Hold `out_ready` = 0 for 3 cycles with `in_valid` = 1 -> `in_ready` = 0 and the bundle is unchanged.
   - Release -> the next instruction loads the following cycle, with no loss or duplication.
   - 10 back-to-back instructions with `out_ready` = 1 -> 10 bundles in order.
5. **Illegal opcode and NOP:** opcode `1100` -> `illegal` = 1, `reg_write` = 0, and `illegal_seen` stays 1 through subsequent legal instructions until reset. NOP -> `reg_write` = 0, `illegal` = 0.
6. **Flush:** `flush` while a bundle is stalled and a new instruction is offered -> `out_valid` = 0 next cycle and both instructions are dropped. A writeback in the same cycle still commits. `rst_n` = 0 mid-stall -> all outputs 0 next cycle.
